fdma_stream_wr: RTL and testbench

- Upstream feeder for the FDMA package-write port.
- Accepts a 32-bit valid/ready word stream (e.g. denoise output), buffers it in an internal FIFO, and issues fixed-size write bursts on pkg_wr_* toward PS DDR.
- Handles frame boundaries: a marked last word flushes a partial burst; the next frame restarts at DDR_BASE.
- Sits between the processing pipeline and the system FDMA instance, in place of the DDR test generator's write side.

---
 rtl/fdma_stream_wr.sv | 191 +++++++++++++++++++
 tb/tb_fdma_stream_wr.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fdma_stream_wr.sv
// -----------------------------------------------------------------------------
// fdma_stream_wr
//   Buffers a 32-bit valid/ready word stream in a first-word-fall-through FIFO
//   and hands it to the FDMA package-write port as fixed-size write bursts.
//   A word marked s_last closes the frame: intake stops, whatever is left in
//   the FIFO goes out as one short flush burst, and the next frame starts
//   again at DDR_BASE. Full-burst addresses advance through a window of
//   DDR_RANGE bytes and fold back to DDR_BASE before a burst would overrun it.
//
// Ports
//   ui_clk, ui_rst       clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready
//                        input word stream (s_last qualified by handshake)
//   pkg_wr_areq          one-cycle burst request
//   pkg_wr_addr/size     burst byte address / word count, stable for the burst
//   pkg_wr_en/last       FDMA consumes a word / marks final beat
//   pkg_wr_data          FIFO head word (0 when FIFO is empty)
//   fifo_level           FIFO occupancy
//   frame_done, wrap     one-cycle status pulses
//   err_underflow        sticky: FDMA consumed from an empty FIFO
// -----------------------------------------------------------------------------
module fdma_stream_wr #(
  parameter logic [31:0] DDR_BASE   = 32'd52428800,
  parameter logic [31:0] DDR_RANGE  = 32'd134217728,
  parameter int          BURST_LEN  = 256,
  parameter int          FIFO_DEPTH = 1024,
  localparam int         AW         = $clog2(FIFO_DEPTH)
) (
  input  logic        ui_clk,
  input  logic        ui_rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        pkg_wr_areq,
  output logic [31:0] pkg_wr_addr,
  output logic [31:0] pkg_wr_size,
  input  logic        pkg_wr_en,
  output logic [31:0] pkg_wr_data,
  input  logic        pkg_wr_last,
  output logic [AW:0] fifo_level,
  output logic        frame_done,
  output logic        wrap,
  output logic        err_underflow
);

  localparam logic [AW:0] DEPTH_L     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] BURST_L     = (AW+1)'(BURST_LEN);
  localparam logic [31:0] BURST_WORDS = 32'(BURST_LEN);
  localparam logic [31:0] BURST_BYTES = BURST_WORDS << 2;
  localparam logic [31:0] WIN_END     = DDR_BASE + DDR_RANGE;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  // ---------------------------------------------------------------- FIFO ----
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          empty, push, pop;

  logic          flush_pend_q, flush_pend_d;

  assign empty   = (level_q == '0);
  // Intake closes while a frame tail is being flushed so the FIFO holds
  // exactly that tail when the flush size is latched.
  assign s_ready = (level_q != DEPTH_L) & ~flush_pend_q;
  assign push    = s_valid & s_ready;
  assign pop     = pkg_wr_en & ~empty;

  always_ff @(posedge ui_clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Head word is read straight from the array: the FDMA samples it in the
  // same cycle it asserts pkg_wr_en.
  assign pkg_wr_data = empty ? 32'd0 : mem_q[rd_ptr_q];
  assign fifo_level  = level_q;

  // ----------------------------------------------------------- burst FSM ----
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] size_q, size_d;
  logic        fl_burst_q, fl_burst_d;
  logic        frame_done_q, frame_done_d;
  logic        wrap_q, wrap_d;
  logic        err_q, err_d;
  logic [31:0] next_addr;

  assign next_addr = addr_q + {size_q[29:0], 2'b00};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    fl_burst_d   = fl_burst_q;
    flush_pend_d = flush_pend_q;
    frame_done_d = 1'b0;
    wrap_d       = 1'b0;
    err_d        = err_q | (pkg_wr_en & empty);

    if (push & s_last) flush_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (level_q >= BURST_L) begin
          size_d  = BURST_WORDS;
          state_d = REQ;
        end else if (flush_pend_q && !empty) begin
          size_d     = 32'(level_q);
          fl_burst_d = 1'b1;
          state_d    = REQ;
        end else if (flush_pend_q) begin
          // Frame ended exactly on a burst boundary (or was empty).
          frame_done_d = 1'b1;
          flush_pend_d = 1'b0;
          addr_d       = DDR_BASE;
        end
      end
      REQ: state_d = DATA;
      DATA: begin
        if (pkg_wr_en && pkg_wr_last) begin
          state_d = IDLE;
          if (fl_burst_q) begin
            addr_d       = DDR_BASE;
            frame_done_d = 1'b1;
            flush_pend_d = 1'b0;
            fl_burst_d   = 1'b0;
          end else if (next_addr + BURST_BYTES > WIN_END) begin
            // Another full burst would run past the window end.
            addr_d = DDR_BASE;
            wrap_d = 1'b1;
          end else begin
            addr_d = next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      state_q      <= IDLE;
      addr_q       <= DDR_BASE;
      size_q       <= '0;
      fl_burst_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      fl_burst_q   <= fl_burst_d;
      flush_pend_q <= flush_pend_d;
      frame_done_q <= frame_done_d;
      wrap_q       <= wrap_d;
      err_q        <= err_d;
    end
  end

  assign pkg_wr_areq   = (state_q == REQ);
  assign pkg_wr_addr   = addr_q;
  assign pkg_wr_size   = size_q;
  assign frame_done    = frame_done_q;
  assign wrap          = wrap_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fdma_stream_wr.sv
// -----------------------------------------------------------------------------
// tb_fdma_stream_wr
//   Directed bench for fdma_stream_wr with a 4 KB address window so the wrap
//   case is reachable. A per-cycle helper drives an incrementing word source
//   and a simple FDMA sink that answers each areq with size beats; expected
//   burst addresses/sizes are queued by hand for each phase.
// -----------------------------------------------------------------------------
module tb_fdma_stream_wr;

  localparam logic [31:0] BASE = 32'h0320_0000;

  logic        clk = 1'b0;
  logic        ui_rst;
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic        pkg_wr_areq;
  logic [31:0] pkg_wr_addr, pkg_wr_size, pkg_wr_data;
  logic        pkg_wr_en, pkg_wr_last;
  logic [10:0] fifo_level;
  logic        frame_done, wrap, err_underflow;

  always #5 clk = ~clk;

  fdma_stream_wr #(
    .DDR_BASE  (BASE),
    .DDR_RANGE (32'd4096),
    .BURST_LEN (256),
    .FIFO_DEPTH(1024)
  ) dut (
    .ui_clk       (clk),
    .ui_rst       (ui_rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .pkg_wr_areq  (pkg_wr_areq),
    .pkg_wr_addr  (pkg_wr_addr),
    .pkg_wr_size  (pkg_wr_size),
    .pkg_wr_en    (pkg_wr_en),
    .pkg_wr_data  (pkg_wr_data),
    .pkg_wr_last  (pkg_wr_last),
    .fifo_level   (fifo_level),
    .frame_done   (frame_done),
    .wrap         (wrap),
    .err_underflow(err_underflow)
  );

  int          total = 0;
  int          bad   = 0;
  int          src_next, src_end, src_last;
  bit          sink_en, flush_wait;
  int          beats_left, beats_done;
  logic [31:0] exp_data;
  int          done_cnt, wrap_cnt;
  logic [31:0] q_addr[$];
  logic [31:0] q_size[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle of source + sink activity. Called at posedge+1.
  task automatic tick();
    logic [31:0] sz;
    s_valid     = (src_next < src_end);
    s_data      = 32'(src_next);
    s_last      = s_valid && (src_next == src_last);
    pkg_wr_en   = sink_en && (beats_left > 0);
    pkg_wr_last = pkg_wr_en && (beats_left == 1);
    #1;
    if (flush_wait && !frame_done) chk("s_ready_low_during_flush", 32'(s_ready), 32'd0);
    if (frame_done) begin done_cnt++; flush_wait = 1'b0; end
    if (wrap) wrap_cnt++;
    if (pkg_wr_en) begin
      chk("wr_data", pkg_wr_data, exp_data);
      exp_data = exp_data + 1;
      beats_left--;
      beats_done++;
    end
    if (pkg_wr_areq) begin
      if (q_addr.size() == 0) begin
        chk("unexpected_areq", 32'd1, 32'd0);
      end else begin
        chk("areq_addr", pkg_wr_addr, q_addr.pop_front());
        sz = q_size.pop_front();
        chk("areq_size", pkg_wr_size, sz);
        beats_left = int'(sz);
        beats_done = 0;
      end
    end
    if (s_valid && s_ready) begin
      if (s_last) flush_wait = 1'b1;
      src_next++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int max_cycles);
    int n = 0;
    while (!(q_addr.size() == 0 && beats_left == 0 && src_next >= src_end && !flush_wait)
           && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < max_cycles), 32'd1);
  endtask

  task automatic exp_burst(input logic [31:0] a, input logic [31:0] s);
    q_addr.push_back(a);
    q_size.push_back(s);
  endtask

  initial begin
    ui_rst = 1'b1; s_valid = 0; s_last = 0; s_data = 0; pkg_wr_en = 0; pkg_wr_last = 0;
    src_next = 0; src_end = 0; src_last = -1; sink_en = 0; flush_wait = 0;
    beats_left = 0; beats_done = 0; exp_data = 0; done_cnt = 0; wrap_cnt = 0;

    // ---- reset for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    ui_rst = 1'b0;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_areq", 32'(pkg_wr_areq), 32'd0);
    chk("rst_addr", pkg_wr_addr, 32'h0320_0000);
    chk("rst_size", pkg_wr_size, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_flags", {29'd0, frame_done, wrap, err_underflow}, 32'd0);
    chk("rst_data", pkg_wr_data, 32'd0);
    $display("step reset: checked");

    // ---- 256 words, no last: one full burst
    src_end = 256; sink_en = 1;
    exp_burst(BASE, 32'd256);
    run("single_burst_complete", 2000);
    repeat (2) tick();
    chk("single_next_addr", pkg_wr_addr, BASE + 32'h400);
    chk("single_level", 32'(fifo_level), 32'd0);
    chk("single_no_done", 32'(done_cnt), 32'd0);
    $display("step single burst: next_addr=0x%08h", pkg_wr_addr);

    // ---- 600-word frame: two full bursts then an 88-word flush
    done_cnt = 0; wrap_cnt = 0;
    src_end = 856; src_last = 855;
    exp_burst(BASE + 32'h400, 32'd256);
    exp_burst(BASE + 32'h800, 32'd256);
    exp_burst(BASE + 32'hC00, 32'd88);
    run("frame600_complete", 4000);
    repeat (2) tick();
    chk("frame600_done_cnt", 32'(done_cnt), 32'd1);
    chk("frame600_wrap_cnt", 32'(wrap_cnt), 32'd0);
    chk("frame600_addr_base", pkg_wr_addr, BASE);
    chk("frame600_s_ready", 32'(s_ready), 32'd1);
    $display("step frame600: frame_done=%0d", done_cnt);

    // ---- stalled FDMA, 1100 words offered (last on final), then drain:
    //      four full bursts fill the 4 KB window, wrap, flush 76 at BASE
    done_cnt = 0; wrap_cnt = 0;
    src_end = 1956; src_last = 1955; sink_en = 0;
    exp_burst(BASE,           32'd256);
    exp_burst(BASE + 32'h400, 32'd256);
    exp_burst(BASE + 32'h800, 32'd256);
    exp_burst(BASE + 32'hC00, 32'd256);
    exp_burst(BASE,           32'd76);
    repeat (1200) tick();
    chk("stall_level_full", 32'(fifo_level), 32'd1024);
    chk("stall_s_ready_low", 32'(s_ready), 32'd0);
    chk("stall_accepted", 32'(src_next), 32'd1880);
    sink_en = 1;
    run("stall_drain_complete", 6000);
    repeat (2) tick();
    chk("stall_done_cnt", 32'(done_cnt), 32'd1);
    chk("stall_wrap_cnt", 32'(wrap_cnt), 32'd1);
    chk("stall_level_zero", 32'(fifo_level), 32'd0);
    chk("stall_all_words", exp_data, 32'd1956);
    $display("step stall/wrap: wraps=%0d words=%0d", wrap_cnt, exp_data);

    // ---- underflow: pkg_wr_en with an empty FIFO
    sink_en = 0;
    s_valid = 0; s_last = 0; pkg_wr_en = 1; pkg_wr_last = 0;
    #1;
    chk("uf_data_zero", pkg_wr_data, 32'd0);
    @(posedge clk); #1;
    pkg_wr_en = 0;
    chk("uf_err_set", 32'(err_underflow), 32'd1);
    chk("uf_level", 32'(fifo_level), 32'd0);
    repeat (3) tick();
    chk("uf_err_sticky", 32'(err_underflow), 32'd1);
    $display("step underflow: err=%0d", err_underflow);

    // ---- reset in the middle of a burst at beat 100
    src_end = src_next + 256; src_last = -1; sink_en = 1;
    exp_burst(BASE, 32'd256);
    begin
      int n = 0;
      while (beats_done < 100 && n < 2000) begin tick(); n++; end
      chk("midrst_reached_beat100", 32'(beats_done), 32'd100);
    end
    ui_rst = 1; s_valid = 0; s_last = 0; pkg_wr_en = 0; pkg_wr_last = 0;
    @(posedge clk); #1;
    ui_rst = 0;
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_err_clear", 32'(err_underflow), 32'd0);
    chk("midrst_areq", 32'(pkg_wr_areq), 32'd0);
    chk("midrst_addr", pkg_wr_addr, BASE);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    q_addr.delete(); q_size.delete();
    beats_left = 0; src_end = src_next; sink_en = 0;
    repeat (5) tick();
    chk("midrst_idle_level", 32'(fifo_level), 32'd0);
    $display("step reset mid-burst: level=%0d", fifo_level);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
